rename_alloc_ctrl: RTL and testbench

- Scheduler in front of the physical-register free list: 4-wide pop (request count plus 4 tags, 1-cycle registered latency) and 4-wide push (return count plus 4 tags).
- Alloc side: gates decode bundles against the available count, issues pops, scatters returned tags to bundle slots, and holds them across rename backpressure.
- Return side: arbitrates ROB-commit frees, squash frees and flush reclaim onto the single 4-port return interface.

---
 rtl/rename_alloc_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rename_alloc_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_alloc_ctrl.sv
// Free-list front end: gates decode bundles on available tags, scatters popped tags to slots (1-cycle pop latency),
// holds them under rename backpressure, and merges commit/squash/flush-reclaim frees onto one registered 4-wide return.
// Optional stall counter output o_stall_cycles under macro RENAME_STALL_CNT_EN.
module rename_alloc_ctrl #(
    parameter int LEN   = 48,
    parameter int LBITS = $clog2(LEN)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_dec_valid,
    input  logic [3:0]       i_dec_need,
    output logic             o_dec_ready,
    output logic [2:0]       o_fl_req_count,
    input  logic [LBITS-1:0] i_fl_req0,
    input  logic [LBITS-1:0] i_fl_req1,
    input  logic [LBITS-1:0] i_fl_req2,
    input  logic [LBITS-1:0] i_fl_req3,
    input  logic [LBITS-1:0] i_fl_avail,
    output logic             o_ren_valid,
    output logic [3:0]       o_ren_need,
    output logic [LBITS-1:0] o_ren_tag0,
    output logic [LBITS-1:0] o_ren_tag1,
    output logic [LBITS-1:0] o_ren_tag2,
    output logic [LBITS-1:0] o_ren_tag3,
    input  logic             i_ren_ready,
    input  logic [2:0]       i_cm_count,
    input  logic [LBITS-1:0] i_cm_p0,
    input  logic [LBITS-1:0] i_cm_p1,
    input  logic [LBITS-1:0] i_cm_p2,
    input  logic [LBITS-1:0] i_cm_p3,
    input  logic [2:0]       i_sq_count,
    input  logic [LBITS-1:0] i_sq_p0,
    input  logic [LBITS-1:0] i_sq_p1,
    input  logic [LBITS-1:0] i_sq_p2,
    input  logic [LBITS-1:0] i_sq_p3,
    output logic             o_sq_ready,
    input  logic             i_flush,
    output logic [2:0]       o_fl_ret_count,
    output logic [LBITS-1:0] o_fl_ret_p0,
    output logic [LBITS-1:0] o_fl_ret_p1,
    output logic [LBITS-1:0] o_fl_ret_p2,
    output logic [LBITS-1:0] o_fl_ret_p3
`ifdef RENAME_STALL_CNT_EN
    ,
    output logic [15:0]      o_stall_cycles
`endif
);
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_PEND = 2'd1, S_HOLD = 2'd2} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_need;
    logic [LBITS-1:0] r_hold [4];
    logic [LBITS-1:0] r_rc [8];
    logic [3:0]       r_rc_cnt;
    logic [2:0]       r_ret_cnt;
    logic [LBITS-1:0] r_ret [4];

    logic [LBITS-1:0] w_req [4];
    logic [LBITS-1:0] w_cm [4];
    logic [LBITS-1:0] w_sq [4];
    logic [LBITS-1:0] w_src [4];
    logic [LBITS-1:0] w_tag [4];
    logic [LBITS-1:0] w_ret [4];
    logic [LBITS-1:0] w_rc_nxt [8];
    logic [2:0]       w_n, w_need_cnt, w_ret_cnt;
    logic [3:0]       w_rc_cnt_nxt;
    logic             w_accept, w_deliver, w_reclaim, w_sq_rdy;

    assign w_req = '{i_fl_req0, i_fl_req1, i_fl_req2, i_fl_req3};
    assign w_cm  = '{i_cm_p0, i_cm_p1, i_cm_p2, i_cm_p3};
    assign w_sq  = '{i_sq_p0, i_sq_p1, i_sq_p2, i_sq_p3};

    assign w_n = 3'(i_dec_need[0]) + 3'(i_dec_need[1]) + 3'(i_dec_need[2]) + 3'(i_dec_need[3]);
    assign w_need_cnt = 3'(r_need[0]) + 3'(r_need[1]) + 3'(r_need[2]) + 3'(r_need[3]);

    assign o_ren_valid    = (r_state != S_EMPTY);
    assign o_ren_need     = r_need;
    assign w_deliver      = o_ren_valid && i_ren_ready;
    assign o_dec_ready    = i_rst_n && !i_flush && (r_rc_cnt == 4'd0) && (LBITS'(w_n) <= i_fl_avail)
                            && ((r_state == S_EMPTY) || w_deliver);
    assign w_accept       = i_dec_valid && o_dec_ready;
    assign o_fl_req_count = w_accept ? w_n : 3'd0;
    assign w_reclaim      = i_flush && o_ren_valid && !i_ren_ready;
    assign o_sq_ready     = w_sq_rdy;

    // Packed tag source: live pop data on the first presentation, captured copy afterwards.
    for (genvar g = 0; g < 4; g++) begin : g_src
        assign w_src[g] = (r_state == S_PEND) ? w_req[g] : r_hold[g];
    end

    always_comb begin
        int idx;
        idx = 0;
        for (int s = 0; s < 4; s++) begin
            w_tag[s] = '0;
            if (o_ren_valid && r_need[s]) begin
                w_tag[s] = w_src[idx[1:0]];
                idx = idx + 1;
            end
        end
    end

    assign o_ren_tag0 = w_tag[0];
    assign o_ren_tag1 = w_tag[1];
    assign o_ren_tag2 = w_tag[2];
    assign o_ren_tag3 = w_tag[3];

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_state_nxt = S_PEND;
                S_PEND, S_HOLD: begin
                    if (i_ren_ready) w_state_nxt = w_accept ? S_PEND : S_EMPTY;
                    else             w_state_nxt = S_HOLD;
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Return list = first segment then second; leftovers (deferred commit, flushed tags) go to the reclaim buffer.
    always_comb begin
        int a, b, rem, dcm, fcnt, tot;
        logic [LBITS-1:0] w_first [4];
        logic [LBITS-1:0] w_second [4];
        w_sq_rdy = 1'b0;
        a = 0; b = 0; rem = 0; dcm = 0;
        w_first  = w_cm;
        w_second = w_sq;
        if (r_rc_cnt != 4'd0) begin
            a   = (r_rc_cnt > 4'd4) ? 4 : int'(r_rc_cnt);
            rem = int'(r_rc_cnt) - a;
            for (int j = 0; j < 4; j++) w_first[j] = r_rc[j];
            w_second = w_cm;
            if (int'(r_rc_cnt) + int'(i_cm_count) <= 4) b = int'(i_cm_count);
            else                                        dcm = int'(i_cm_count);
        end else begin
            w_sq_rdy = (int'(i_cm_count) + int'(i_sq_count)) <= 4;
            a = int'(i_cm_count);
            b = w_sq_rdy ? int'(i_sq_count) : 0;
        end
        for (int j = 0; j < 4; j++) begin
            w_ret[j] = '0;
            if (j < a)          w_ret[j] = w_first[j];
            else if (j < a + b) w_ret[j] = w_second[2'(j - a)];
        end
        w_ret_cnt = 3'(a + b);
        fcnt = w_reclaim ? int'(w_need_cnt) : 0;
        for (int j = 0; j < 8; j++) begin
            w_rc_nxt[j] = '0;
            if (j < rem)                   w_rc_nxt[j] = r_rc[3'(j + a)];
            else if (j < rem + dcm)        w_rc_nxt[j] = w_cm[2'(j - rem)];
            else if (j < rem + dcm + fcnt) w_rc_nxt[j] = w_src[2'(j - rem - dcm)];
        end
        tot = rem + dcm + fcnt;
        w_rc_cnt_nxt = (tot > 8) ? 4'd8 : 4'(tot);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_EMPTY;
            r_need    <= '0;
            r_rc_cnt  <= '0;
            r_ret_cnt <= '0;
            for (int j = 0; j < 4; j++) begin
                r_hold[j] <= '0;
                r_ret[j]  <= '0;
            end
            for (int j = 0; j < 8; j++) r_rc[j] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_need <= i_dec_need;
            if (r_state == S_PEND) r_hold <= w_req;
            r_rc      <= w_rc_nxt;
            r_rc_cnt  <= w_rc_cnt_nxt;
            r_ret_cnt <= w_ret_cnt;
            r_ret     <= w_ret;
        end
    end

    assign o_fl_ret_count = r_ret_cnt;
    assign o_fl_ret_p0    = r_ret[0];
    assign o_fl_ret_p1    = r_ret[1];
    assign o_fl_ret_p2    = r_ret[2];
    assign o_fl_ret_p3    = r_ret[3];

`ifdef RENAME_STALL_CNT_EN
    logic [15:0] r_stall;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall <= '0;
        end else if (i_dec_valid && !i_flush && (LBITS'(w_n) > i_fl_avail) && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end
    assign o_stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Bench for rename_alloc_ctrl: directed scenarios plus a randomized run against a queue-based reference model.
module tb_rename_alloc_ctrl;
    localparam int LEN   = 48;
    localparam int LBITS = $clog2(LEN);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, dec_valid, dec_ready, ren_valid, ren_ready, sq_ready, flush;
    logic [3:0] dec_need, ren_need;
    logic [2:0] fl_req_count, cm_count, sq_count, ret_count;
    logic [LBITS-1:0] fl_avail;
    logic [3:0][LBITS-1:0] fl_req, ren_tag, cm_p, sq_p, ret_p;
`ifdef RENAME_STALL_CNT_EN
    logic [15:0] stall_cycles;
    int m_stall = 0;
`endif
    int checks = 0;
    int errors = 0;

    rename_alloc_ctrl #(.LEN(LEN)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dec_valid(dec_valid), .i_dec_need(dec_need),
        .o_dec_ready(dec_ready), .o_fl_req_count(fl_req_count),
        .i_fl_req0(fl_req[0]), .i_fl_req1(fl_req[1]), .i_fl_req2(fl_req[2]), .i_fl_req3(fl_req[3]),
        .i_fl_avail(fl_avail), .o_ren_valid(ren_valid), .o_ren_need(ren_need),
        .o_ren_tag0(ren_tag[0]), .o_ren_tag1(ren_tag[1]), .o_ren_tag2(ren_tag[2]), .o_ren_tag3(ren_tag[3]),
        .i_ren_ready(ren_ready), .i_cm_count(cm_count),
        .i_cm_p0(cm_p[0]), .i_cm_p1(cm_p[1]), .i_cm_p2(cm_p[2]), .i_cm_p3(cm_p[3]),
        .i_sq_count(sq_count),
        .i_sq_p0(sq_p[0]), .i_sq_p1(sq_p[1]), .i_sq_p2(sq_p[2]), .i_sq_p3(sq_p[3]),
        .o_sq_ready(sq_ready), .i_flush(flush), .o_fl_ret_count(ret_count),
        .o_fl_ret_p0(ret_p[0]), .o_fl_ret_p1(ret_p[1]), .o_fl_ret_p2(ret_p[2]), .o_fl_ret_p3(ret_p[3])
`ifdef RENAME_STALL_CNT_EN
        , .o_stall_cycles(stall_cycles)
`endif
    );

`ifdef RENAME_STALL_CNT_EN
    always @(posedge clk) begin
        if (!rst_n) m_stall <= 0;
        else if (dec_valid && !flush && ($countones(dec_need) > int'(fl_avail)) && m_stall < 65535)
            m_stall <= m_stall + 1;
    end
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        dec_valid = 1'b0; dec_need = 4'b0000; fl_avail = LBITS'(LEN); ren_ready = 1'b1; flush = 1'b0;
        cm_count = 3'd0; sq_count = 3'd0;
        for (int k = 0; k < 4; k++) begin
            fl_req[k] = LBITS'($urandom_range(0, LEN - 1));
            cm_p[k] = '0;
            sq_p[k] = '0;
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        dec_valid = 1'b1; dec_need = 4'b1111;
        step(); step();
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL reset_dec_ready: got %0d expected 0", dec_ready); end
        checks++; if (fl_req_count !== 3'd0) begin errors++; $display("FAIL reset_req_count: got %0d expected 0", fl_req_count); end
        checks++; if (ren_valid !== 1'b0) begin errors++; $display("FAIL reset_ren_valid: got %0d expected 0", ren_valid); end
        checks++; if (ret_count !== 3'd0) begin errors++; $display("FAIL reset_ret_count: got %0d expected 0", ret_count); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (ret_p[k] !== '0) begin errors++; $display("FAIL reset_ret_p%0d: got %0d expected 0", k, ret_p[k]); end
        end
        set_idle();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alloc_basic();
        set_idle();
        dec_valid = 1'b1; dec_need = 4'b1011;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL basic_dec_ready: got %0d expected 1", dec_ready); end
        checks++; if (fl_req_count !== 3'd3) begin errors++; $display("FAIL basic_req_count: got %0d expected 3", fl_req_count); end
        step();
        dec_valid = 1'b0;
        fl_req[0] = 5; fl_req[1] = 6; fl_req[2] = 7; fl_req[3] = 33;
        #1;
        checks++; if (ren_valid !== 1'b1) begin errors++; $display("FAIL basic_ren_valid: got %0d expected 1", ren_valid); end
        checks++; if (ren_need !== 4'b1011) begin errors++; $display("FAIL basic_ren_need: got %b expected 1011", ren_need); end
        checks++; if (ren_tag[0] !== 5) begin errors++; $display("FAIL basic_tag0: got %0d expected 5", ren_tag[0]); end
        checks++; if (ren_tag[1] !== 6) begin errors++; $display("FAIL basic_tag1: got %0d expected 6", ren_tag[1]); end
        checks++; if (ren_tag[2] !== 0) begin errors++; $display("FAIL basic_tag2: got %0d expected 0", ren_tag[2]); end
        checks++; if (ren_tag[3] !== 7) begin errors++; $display("FAIL basic_tag3: got %0d expected 7", ren_tag[3]); end
        step();
        checks++; if (ren_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %0d expected 0", ren_valid); end
    endtask

    task automatic test_hold();
        logic [LBITS-1:0] exp [4];
        exp = '{5, 6, 0, 7};
        set_idle();
        dec_valid = 1'b1; dec_need = 4'b1011;
        step();
        dec_valid = 1'b0; ren_ready = 1'b0;
        fl_req[0] = 5; fl_req[1] = 6; fl_req[2] = 7; fl_req[3] = 8;
        for (int c = 0; c < 4; c++) begin
            if (c > 0)
                for (int k = 0; k < 4; k++) fl_req[k] = LBITS'($urandom_range(11, LEN - 1));
            if (c == 3) ren_ready = 1'b1;
            #1;
            checks++; if (ren_valid !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d: got %0d expected 1", c, ren_valid); end
            for (int s = 0; s < 4; s++) begin
                checks++;
                if (ren_tag[s] !== exp[s]) begin
                    errors++; $display("FAIL hold_tag%0d c%0d: got %0d expected %0d", s, c, ren_tag[s], exp[s]);
                end
            end
            checks++;
            if (dec_ready !== (c == 3)) begin
                errors++; $display("FAIL hold_dec_ready c%0d: got %0d expected %0d", c, dec_ready, c == 3);
            end
            step();
        end
        checks++; if (ren_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %0d expected 0", ren_valid); end
    endtask

    task automatic test_stall();
        set_idle();
        fl_avail = 2; dec_valid = 1'b1; dec_need = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL stall_dec_ready c%0d: got %0d expected 0", c, dec_ready); end
            checks++; if (fl_req_count !== 3'd0) begin errors++; $display("FAIL stall_req_count c%0d: got %0d expected 0", c, fl_req_count); end
            step();
`ifdef RENAME_STALL_CNT_EN
            checks++;
            if (stall_cycles !== 16'(m_stall) || m_stall < c + 1) begin
                errors++; $display("FAIL stall_cycles c%0d: got %0d expected %0d", c, stall_cycles, m_stall);
            end
`endif
        end
        fl_avail = 3;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0d expected 1", dec_ready); end
        checks++; if (fl_req_count !== 3'd3) begin errors++; $display("FAIL stall_release_req: got %0d expected 3", fl_req_count); end
        step();
        set_idle();
        step();
    endtask

    task automatic test_flush_reclaim();
        set_idle();
        dec_valid = 1'b1; dec_need = 4'b0011;
        step();
        set_idle();
        ren_ready = 1'b0; fl_req[0] = 9; fl_req[1] = 10;
        step();
        ren_ready = 1'b0; flush = 1'b1;
        #1;
        checks++; if (ren_tag[0] !== 9 || ren_tag[1] !== 10) begin
            errors++; $display("FAIL flush_held_tags: got %0d,%0d expected 9,10", ren_tag[0], ren_tag[1]);
        end
        step();
        set_idle();
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_dec_ready_blocked: got %0d expected 0", dec_ready); end
        checks++; if (ren_valid !== 1'b0) begin errors++; $display("FAIL flush_ren_valid: got %0d expected 0", ren_valid); end
        step();
        checks++; if (ret_count !== 3'd2) begin errors++; $display("FAIL flush_ret_count: got %0d expected 2", ret_count); end
        checks++; if (ret_p[0] !== 9 || ret_p[1] !== 10 || ret_p[2] !== 0 || ret_p[3] !== 0) begin
            errors++; $display("FAIL flush_ret_tags: got %0d,%0d,%0d,%0d expected 9,10,0,0", ret_p[0], ret_p[1], ret_p[2], ret_p[3]);
        end
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL flush_dec_ready_after: got %0d expected 1", dec_ready); end
    endtask

    task automatic test_commit_squash();
        set_idle();
        cm_count = 3; cm_p[0] = 1; cm_p[1] = 2; cm_p[2] = 3;
        sq_count = 2; sq_p[0] = 4; sq_p[1] = 5;
        #1;
        checks++; if (sq_ready !== 1'b0) begin errors++; $display("FAIL cs_sq_ready_low: got %0d expected 0", sq_ready); end
        step();
        cm_count = 0;
        #1;
        checks++; if (sq_ready !== 1'b1) begin errors++; $display("FAIL cs_sq_ready_high: got %0d expected 1", sq_ready); end
        checks++; if (ret_count !== 3'd3) begin errors++; $display("FAIL cs_ret_count3: got %0d expected 3", ret_count); end
        checks++; if (ret_p[0] !== 1 || ret_p[1] !== 2 || ret_p[2] !== 3 || ret_p[3] !== 0) begin
            errors++; $display("FAIL cs_ret_commit: got %0d,%0d,%0d,%0d expected 1,2,3,0", ret_p[0], ret_p[1], ret_p[2], ret_p[3]);
        end
        step();
        sq_count = 0;
        #1;
        checks++; if (ret_count !== 3'd2) begin errors++; $display("FAIL cs_ret_count2: got %0d expected 2", ret_count); end
        checks++; if (ret_p[0] !== 4 || ret_p[1] !== 5 || ret_p[2] !== 0 || ret_p[3] !== 0) begin
            errors++; $display("FAIL cs_ret_squash: got %0d,%0d,%0d,%0d expected 4,5,0,0", ret_p[0], ret_p[1], ret_p[2], ret_p[3]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [LBITS-1:0] t [4];
        set_idle();
        cm_count = 2; cm_p[0] = 11; cm_p[1] = 12;
        sq_count = 2; sq_p[0] = 13; sq_p[1] = 14;
        dec_valid = 1'b1; dec_need = 4'b1111;
        #1;
        checks++; if (sq_ready !== 1'b1) begin errors++; $display("FAIL b2b_sq_ready: got %0d expected 1", sq_ready); end
        checks++; if (fl_req_count !== 3'd4) begin errors++; $display("FAIL b2b_req0: got %0d expected 4", fl_req_count); end
        step();
        cm_count = 0; sq_count = 0;
        for (int k = 0; k < 4; k++) begin t[k] = LBITS'($urandom_range(0, LEN - 1)); fl_req[k] = t[k]; end
        dec_need = 4'b0101;
        #1;
        checks++; if (ret_count !== 3'd4 || ret_p[0] !== 11 || ret_p[1] !== 12 || ret_p[2] !== 13 || ret_p[3] !== 14) begin
            errors++; $display("FAIL b2b_ret: got %0d:%0d,%0d,%0d,%0d expected 4:11,12,13,14", ret_count, ret_p[0], ret_p[1], ret_p[2], ret_p[3]);
        end
        checks++; if (ren_tag !== {t[3], t[2], t[1], t[0]}) begin errors++; $display("FAIL b2b_tags0: got %h expected %h", ren_tag, {t[3], t[2], t[1], t[0]}); end
        checks++; if (dec_ready !== 1'b1 || fl_req_count !== 3'd2) begin
            errors++; $display("FAIL b2b_accept1: got ready %0d req %0d expected ready 1 req 2", dec_ready, fl_req_count);
        end
        step();
        for (int k = 0; k < 4; k++) begin t[k] = LBITS'($urandom_range(0, LEN - 1)); fl_req[k] = t[k]; end
        dec_need = 4'b0000;
        #1;
        checks++; if (ren_tag !== {{LBITS{1'b0}}, t[1], {LBITS{1'b0}}, t[0]}) begin
            errors++; $display("FAIL b2b_tags1: got %h expected %h", ren_tag, {{LBITS{1'b0}}, t[1], {LBITS{1'b0}}, t[0]});
        end
        checks++; if (dec_ready !== 1'b1 || fl_req_count !== 3'd0) begin
            errors++; $display("FAIL b2b_accept2: got ready %0d req %0d expected ready 1 req 0", dec_ready, fl_req_count);
        end
        step();
        dec_valid = 1'b0;
        #1;
        checks++; if (ren_valid !== 1'b1 || ren_need !== 4'b0000 || ren_tag !== '0) begin
            errors++; $display("FAIL b2b_empty_bundle: got valid %0d need %b tags %h expected 1 0000 0", ren_valid, ren_need, ren_tag);
        end
        step();
    endtask

    task automatic test_random(input int ncyc);
        logic m_have, m_fresh, exp_rdy, exp_sq;
        logic [3:0] m_need;
        logic [LBITS-1:0] m_tags[$], m_rc[$], exp_ret[$], cmq[$], sqq[$], nxt[$];
        logic [LBITS-1:0] e;
        int n, idx;
        set_idle();
        step();
        m_have = 1'b0; m_fresh = 1'b0; m_need = '0;
        m_tags = {}; m_rc = {}; exp_ret = {};
        for (int c = 0; c < ncyc; c++) begin
            checks++;
            if (int'(ret_count) != exp_ret.size()) begin
                errors++; $display("FAIL rnd_ret_count c%0d: got %0d expected %0d", c, ret_count, exp_ret.size());
            end
            for (int k = 0; k < 4; k++) begin
                e = (k < exp_ret.size()) ? exp_ret[k] : '0;
                checks++; if (ret_p[k] !== e) begin errors++; $display("FAIL rnd_ret_p%0d c%0d: got %0d expected %0d", k, c, ret_p[k], e); end
            end
            checks++; if (ren_valid !== m_have) begin errors++; $display("FAIL rnd_ren_valid c%0d: got %0d expected %0d", c, ren_valid, m_have); end
`ifdef RENAME_STALL_CNT_EN
            checks++; if (stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall c%0d: got %0d expected %0d", c, stall_cycles, m_stall); end
`endif
            dec_valid = ($urandom_range(0, 3) != 0);
            dec_need  = 4'($urandom);
            fl_avail  = ($urandom_range(0, 5) == 0) ? LBITS'($urandom_range(0, 4)) : LBITS'(LEN);
            ren_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            cm_count  = 3'($urandom_range(0, 4));
            sq_count  = 3'($urandom_range(0, 4));
            for (int k = 0; k < 4; k++) begin
                fl_req[k] = LBITS'($urandom_range(0, LEN - 1));
                cm_p[k]   = LBITS'($urandom_range(0, LEN - 1));
                sq_p[k]   = LBITS'($urandom_range(0, LEN - 1));
            end
            if (m_fresh) begin
                m_tags = {};
                for (int k = 0; k < $countones(m_need); k++) m_tags.push_back(fl_req[k]);
                m_fresh = 1'b0;
            end
            #1;
            n = $countones(dec_need);
            exp_rdy = !flush && (m_rc.size() == 0) && (n <= int'(fl_avail)) && (!m_have || ren_ready);
            checks++; if (dec_ready !== exp_rdy) begin errors++; $display("FAIL rnd_dec_ready c%0d: got %0d expected %0d", c, dec_ready, exp_rdy); end
            checks++;
            if (int'(fl_req_count) != ((dec_valid && exp_rdy) ? n : 0)) begin
                errors++; $display("FAIL rnd_req_count c%0d: got %0d expected %0d", c, fl_req_count, (dec_valid && exp_rdy) ? n : 0);
            end
            if (m_have) begin
                idx = 0;
                for (int s = 0; s < 4; s++) begin
                    e = '0;
                    if (m_need[s]) begin e = m_tags[idx]; idx++; end
                    checks++; if (ren_tag[s] !== e) begin errors++; $display("FAIL rnd_tag%0d c%0d: got %0d expected %0d", s, c, ren_tag[s], e); end
                end
            end
            cmq = {}; sqq = {}; nxt = {};
            for (int k = 0; k < int'(cm_count); k++) cmq.push_back(cm_p[k]);
            for (int k = 0; k < int'(sq_count); k++) sqq.push_back(sq_p[k]);
            if (m_rc.size() > 0) begin
                exp_sq = 1'b0;
                while (nxt.size() < 4 && m_rc.size() > 0) nxt.push_back(m_rc.pop_front());
                if (m_rc.size() == 0 && nxt.size() + cmq.size() <= 4) nxt = {nxt, cmq};
                else m_rc = {m_rc, cmq};
            end else begin
                exp_sq = (cmq.size() + sqq.size() <= 4);
                nxt = cmq;
                if (exp_sq) nxt = {nxt, sqq};
            end
            checks++; if (sq_ready !== exp_sq) begin errors++; $display("FAIL rnd_sq_ready c%0d: got %0d expected %0d", c, sq_ready, exp_sq); end
            if (flush && m_have && !ren_ready) m_rc = {m_rc, m_tags};
            if (flush) m_have = 1'b0;
            else if (dec_valid && exp_rdy) begin m_have = 1'b1; m_need = dec_need; m_fresh = 1'b1; end
            else if (m_have && ren_ready) m_have = 1'b0;
            exp_ret = nxt;
            step();
        end
        set_idle();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_alloc_basic();
        test_hold();
        test_stall();
        test_flush_reclaim();
        test_commit_squash();
        test_back_to_back();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
